// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and the
// bit layout of one packed segment record {max, dir, laps, hold}.
package counter_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_LOAD = 3'd1;
  localparam state_t S_RUN  = 3'd2;
  localparam state_t S_HOLD = 3'd3;
  localparam state_t S_DONE = 3'd4;

  // Record layout, LSB first: hold, laps, dir, max.
  function automatic int rec_width(input int width, input int lapw, input int holdw);
    return width + 1 + lapw + holdw;
  endfunction

  function automatic int laps_lsb(input int holdw);
    return holdw;
  endfunction

  function automatic int dir_lsb(input int lapw, input int holdw);
    return lapw + holdw;
  endfunction

  function automatic int max_lsb(input int lapw, input int holdw);
    return lapw + holdw + 1;
  endfunction

endpackage

// File: rtl/counter_sequencer_seg_cfg_regfile.sv
// Segment program storage: one write port, an async read at i_raddr and a
// second async read at i_raddr+1 (wraps) used to look ahead to the next segment.
module seg_cfg_regfile
  import counter_sequencer_pkg::*;
#(
  parameter int NSEG  = 4,
  parameter int REC_W = rec_width(8, 4, 4),
  localparam int IW   = $clog2(NSEG)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [IW-1:0]    i_waddr,
  input  logic [REC_W-1:0] i_wdata,
  input  logic [IW-1:0]    i_raddr,
  output logic [REC_W-1:0] o_rdata,
  output logic [REC_W-1:0] o_rdata_nxt
);

  logic [REC_W-1:0] r_mem [NSEG];
  logic [IW-1:0]    w_raddr_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NSEG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign w_raddr_nxt = i_raddr + IW'(1);
  assign o_rdata     = r_mem[i_raddr];
  assign o_rdata_nxt = r_mem[w_raddr_nxt];

endmodule

// File: rtl/counter_sequencer.sv
// Sequences an external up/down counter through a stored list of segments,
// counting laps at the terminal value and inserting optional pause intervals.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NSEG  = 4,
  parameter int LAPW  = 4,
  parameter int HOLDW = 4,
  localparam int IW   = $clog2(NSEG)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_we,
  input  logic [IW-1:0]    i_cfg_idx,
  input  logic [WIDTH-1:0] i_cfg_max,
  input  logic             i_cfg_dir,
  input  logic [LAPW-1:0]  i_cfg_laps,
  input  logic [HOLDW-1:0] i_cfg_hold,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_cnt_value,
  output logic             o_cnt_rst,
  output logic             o_cnt_dir,
  output logic [WIDTH-1:0] o_cnt_max,
  output logic             o_cnt_pause,
  output logic             o_busy,
  output logic             o_done,
  output logic [IW-1:0]    o_seg_idx,
  output logic             o_err
);

  localparam int REC_W    = rec_width(WIDTH, LAPW, HOLDW);
  localparam int LAPS_LSB = laps_lsb(HOLDW);
  localparam int DIR_LSB  = dir_lsb(LAPW, HOLDW);
  localparam int MAX_LSB  = max_lsb(LAPW, HOLDW);
  localparam logic [REC_W-1:0] REC_RST = REC_W'(1) << DIR_LSB;

  state_t           r_state, w_next;
  logic [REC_W-1:0] r_seg;
  logic [IW-1:0]    r_seg_idx;
  logic [LAPW-1:0]  r_laps;
  logic [HOLDW-1:0] r_hold;
  logic             r_arm, r_err, r_empty_done;

  logic [REC_W-1:0] w_wr_rec, w_rd, w_rd_nxt, w_seg0, w_load_rec;
  logic [IW-1:0]    w_raddr;
  logic [WIDTH-1:0] w_seg_max, w_term;
  logic             w_seg_dir;
  logic [LAPW-1:0]  w_seg_laps, w_laps_inc;
  logic [HOLDW-1:0] w_seg_hold;
  logic             w_idle_like, w_busy, w_wr_en, w_start_ok, w_seg0_empty;
  logic             w_hit, w_lap_exit, w_hold_exit, w_last;

  seg_cfg_regfile #(.NSEG(NSEG), .REC_W(REC_W)) u_regfile (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_we        (w_wr_en),
    .i_waddr     (i_cfg_idx),
    .i_wdata     (w_wr_rec),
    .i_raddr     (w_raddr),
    .o_rdata     (w_rd),
    .o_rdata_nxt (w_rd_nxt)
  );

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_busy      = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_HOLD);
  assign w_wr_en     = i_cfg_we && !w_busy;
  assign w_wr_rec    = {i_cfg_max, i_cfg_dir, i_cfg_laps, i_cfg_hold};
  assign w_raddr     = w_idle_like ? '0 : r_seg_idx;

  // A write to segment 0 on the start edge must be seen by the start check.
  assign w_seg0       = (w_wr_en && (i_cfg_idx == '0)) ? w_wr_rec : w_rd;
  assign w_seg0_empty = (w_seg0[LAPS_LSB +: LAPW] == '0);
  assign w_start_ok   = w_idle_like && i_start && !i_abort;
  assign w_load_rec   = w_idle_like ? w_seg0 : w_rd_nxt;

  assign w_seg_max  = r_seg[MAX_LSB +: WIDTH];
  assign w_seg_dir  = r_seg[DIR_LSB];
  assign w_seg_laps = r_seg[LAPS_LSB +: LAPW];
  assign w_seg_hold = r_seg[0 +: HOLDW];

  assign w_term      = w_seg_dir ? w_seg_max : '0;
  assign w_laps_inc  = (&r_laps) ? r_laps : r_laps + LAPW'(1);
  assign w_hit       = (r_state == S_RUN) && r_arm && (i_cnt_value == w_term);
  assign w_lap_exit  = w_hit && (w_laps_inc == w_seg_laps);
  assign w_hold_exit = (r_hold == w_seg_hold - HOLDW'(1));
  assign w_last      = (r_seg_idx == IW'(NSEG - 1)) || (w_rd_nxt[LAPS_LSB +: LAPW] == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = (w_start_ok && !w_seg0_empty) ? S_LOAD : S_IDLE;
      S_LOAD:         w_next = S_RUN;
      S_RUN: begin
        if (w_lap_exit) begin
          if (w_seg_hold != '0) w_next = S_HOLD;
          else                  w_next = w_last ? S_DONE : S_LOAD;
        end
      end
      S_HOLD:  if (w_hold_exit) w_next = w_last ? S_DONE : S_LOAD;
      default: w_next = S_IDLE;
    endcase
    if (i_abort && w_busy) w_next = S_IDLE;
  end

  // Segment record, index and lap/hold counters; seg_idx survives abort.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seg        <= REC_RST;
      r_seg_idx    <= '0;
      r_laps       <= '0;
      r_hold       <= '0;
      r_arm        <= 1'b0;
      r_err        <= 1'b0;
      r_empty_done <= 1'b0;
    end else begin
      r_empty_done <= w_start_ok && w_seg0_empty;
      if (w_start_ok) r_err <= w_seg0_empty;
      if (w_next == S_LOAD) begin
        r_seg     <= w_load_rec;
        r_seg_idx <= w_idle_like ? '0 : r_seg_idx + IW'(1);
        r_laps    <= '0;
        r_hold    <= '0;
        r_arm     <= 1'b0;
      end else begin
        if (r_state == S_RUN)  r_arm  <= 1'b1;
        if (w_hit)             r_laps <= w_laps_inc;
        if (r_state == S_HOLD) r_hold <= r_hold + HOLDW'(1);
      end
    end
  end

  always_comb begin
    o_busy      = w_busy;
    o_cnt_rst   = (r_state == S_LOAD);
    o_cnt_pause = (r_state != S_RUN);
    o_done      = (r_state == S_DONE) || r_empty_done;
    o_cnt_max   = w_seg_max;
    o_cnt_dir   = w_seg_dir;
    o_seg_idx   = r_seg_idx;
    o_err       = r_err;
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: drives programs into the sequencer wired to a
// simple up/down counter and checks every output cycle against a trace model.
module tb_counter_sequencer;

  localparam int NSEG = 4;

  logic       clk, rst;
  logic       cfg_we, cfg_dir, start, abort;
  logic [1:0] cfg_idx;
  logic [7:0] cfg_max, cnt_value;
  logic [3:0] cfg_laps, cfg_hold;
  logic       cnt_rst, cnt_dir, cnt_pause, busy, done, err;
  logic [7:0] cnt_max;
  logic [1:0] seg_idx;

  int total = 0;
  int bad   = 0;

  // Program image and the output values the model expects to persist.
  logic [7:0] p_max [NSEG];
  logic       p_dir [NSEG];
  logic [3:0] p_laps[NSEG];
  logic [3:0] p_hold[NSEG];
  logic [1:0] m_seg;
  logic       m_dir, m_err;
  logic [7:0] m_max;

  logic [15:0] exp_q[$];

  counter_sequencer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cfg_we    (cfg_we),
    .i_cfg_idx   (cfg_idx),
    .i_cfg_max   (cfg_max),
    .i_cfg_dir   (cfg_dir),
    .i_cfg_laps  (cfg_laps),
    .i_cfg_hold  (cfg_hold),
    .i_start     (start),
    .i_abort     (abort),
    .i_cnt_value (cnt_value),
    .o_cnt_rst   (cnt_rst),
    .o_cnt_dir   (cnt_dir),
    .o_cnt_max   (cnt_max),
    .o_cnt_pause (cnt_pause),
    .o_busy      (busy),
    .o_done      (done),
    .o_seg_idx   (seg_idx),
    .o_err       (err)
  );

  // Counter8bit stand-in, following its documented contract.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt_value <= '0;
    else if (cnt_rst)    cnt_value <= '0;
    else if (!cnt_pause) begin
      if (cnt_dir) cnt_value <= (cnt_value == cnt_max) ? 8'd0 : cnt_value + 8'd1;
      else         cnt_value <= (cnt_value == 8'd0) ? cnt_max : cnt_value - 8'd1;
    end
  end

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] pack(input logic e, input logic b, input logic r,
                                       input logic p, input logic d, input logic [1:0] s,
                                       input logic dr, input logic [7:0] mx);
    return {e, b, r, p, d, s, dr, mx};
  endfunction

  function automatic logic [15:0] obs();
    return pack(err, busy, cnt_rst, cnt_pause, done, seg_idx, cnt_dir, cnt_max);
  endfunction

  task automatic check(input string tag, input int idx, input logic [15:0] got,
                       input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, idx, got, want);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NSEG; i++) begin
      p_max[i] = '0; p_dir[i] = 1'b0; p_laps[i] = '0; p_hold[i] = '0;
    end
    m_seg = '0; m_dir = 1'b1; m_max = '0; m_err = 1'b0;
  endfunction

  // RUN cycles: the first cycle always shows 0 and is skipped; laps then
  // land every max+1 cycles once the counter reaches its terminal value.
  function automatic int run_len(input int s);
    int m, l, first;
    m = int'(p_max[s]);
    l = int'(p_laps[s]);
    if (p_dir[s]) first = (m == 0) ? 2 : m + 1;
    else          first = m + 2;
    return first + (l - 1) * (m + 1);
  endfunction

  function automatic void build_trace();
    bit last;
    exp_q.delete();
    if (p_laps[0] == 0) begin
      m_err = 1'b1;
      exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, m_seg, m_dir, m_max));
    end else begin
      m_err = 1'b0;
      for (int s = 0; s < NSEG; s++) begin
        m_seg = 2'(s); m_dir = p_dir[s]; m_max = p_max[s];
        exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, m_seg, m_dir, m_max));
        for (int k = 0; k < run_len(s); k++)
          exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m_seg, m_dir, m_max));
        for (int k = 0; k < int'(p_hold[s]); k++)
          exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, m_seg, m_dir, m_max));
        last = (s == NSEG - 1);
        if (!last) last = (p_laps[s + 1] == 0);
        if (last) begin
          exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, m_seg, m_dir, m_max));
          break;
        end
      end
    end
    for (int k = 0; k < 2; k++)
      exp_q.push_back(pack(m_err, 1'b0, 1'b0, 1'b1, 1'b0, m_seg, m_dir, m_max));
  endfunction

  // Driver tasks.
  task automatic write_seg(input int idx, input logic [7:0] mx, input logic dr,
                           input logic [3:0] laps, input logic [3:0] hold);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_max = mx; cfg_dir = dr;
    cfg_laps = laps; cfg_hold = hold;
    p_max[idx] = mx; p_dir[idx] = dr; p_laps[idx] = laps; p_hold[idx] = hold;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic start_prog(input bit wr0, input logic [7:0] mx, input logic dr,
                            input logic [3:0] laps, input logic [3:0] hold);
    @(negedge clk);
    if (wr0) begin
      cfg_we = 1'b1; cfg_idx = 2'd0; cfg_max = mx; cfg_dir = dr;
      cfg_laps = laps; cfg_hold = hold;
      p_max[0] = mx; p_dir[0] = dr; p_laps[0] = laps; p_hold[0] = hold;
    end
    start = 1'b1;
    build_trace();
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic check_trace(input string tag, input int abort_at, input int inject_at,
                             input int rst_at);
    logic [15:0] e, a_exp;
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check(tag, i, obs(), e);
      if (i == abort_at) begin
        a_exp = e;
        a_exp[14] = 1'b0; a_exp[13] = 1'b0; a_exp[11] = 1'b0; a_exp[12] = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check({tag, "_abort"}, i + 1 + k, obs(), a_exp);
        end
        m_err = e[15]; m_seg = e[10:9]; m_dir = e[8]; m_max = e[7:0];
        exp_q.delete();
        break;
      end
      if (i == rst_at) begin
        #2 rst = 1'b1;
        #1 check({tag, "_async_rst"}, i, obs(), pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 8'd0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        break;
      end
      if (i == inject_at) begin
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_max = 8'hAA; cfg_dir = 1'b0;
        cfg_laps = 4'd0; cfg_hold = 4'd7; start = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0;
      end
      i++;
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_max = '0; cfg_dir = 1'b0;
    cfg_laps = '0; cfg_hold = '0; start = 1'b0; abort = 1'b0;
    model_reset();

    // Reset and idle; empty program start.
    @(negedge clk);
    check("in_reset", 0, obs(), pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 8'd0));
    #10 rst = 1'b0;
    @(negedge clk);
    check("after_reset", 0, obs(), pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 8'd0));
    start_prog(1'b0, 8'd0, 1'b0, 4'd0, 4'd0);
    check_trace("empty_start", -1, -1, -1);

    // Single up segment with hold.
    write_seg(0, 8'd5, 1'b1, 4'd2, 4'd3);
    write_seg(1, 8'd9, 1'b1, 4'd0, 4'd0);
    start_prog(1'b0, 8'd0, 1'b0, 4'd0, 4'd0);
    check_trace("up_hold", -1, -1, -1);

    // Multi-segment with direction change, then abort in seg1 RUN and restart.
    write_seg(0, 8'h0F, 1'b1, 4'd1, 4'd0);
    write_seg(1, 8'd7,  1'b0, 4'd1, 4'd2);
    write_seg(2, 8'h20, 1'b1, 4'd1, 4'd0);
    write_seg(3, 8'd3,  1'b0, 4'd0, 4'd0);
    start_prog(1'b0, 8'd0, 1'b0, 4'd0, 4'd0);
    check_trace("multi", -1, -1, -1);
    start_prog(1'b0, 8'd0, 1'b0, 4'd0, 4'd0);
    check_trace("abort", 19, -1, -1);
    start_prog(1'b0, 8'd0, 1'b0, 4'd0, 4'd0);
    check_trace("restart", -1, -1, -1);

    // Writes and start while busy are ignored; async reset during HOLD.
    write_seg(0, 8'd5, 1'b1, 4'd2, 4'd3);
    write_seg(1, 8'd7, 1'b0, 4'd0, 4'd0);
    start_prog(1'b0, 8'd0, 1'b0, 4'd0, 4'd0);
    check_trace("busy_inject", -1, 5, -1);
    start_prog(1'b0, 8'd0, 1'b0, 4'd0, 4'd0);
    check_trace("cfg_frozen", -1, -1, -1);
    start_prog(1'b0, 8'd0, 1'b0, 4'd0, 4'd0);
    check_trace("rst_in_hold", -1, -1, 14);

    // Write to seg0 on the same edge as start.
    start_prog(1'b1, 8'd2, 1'b1, 4'd1, 4'd0);
    check_trace("write_with_start", -1, -1, -1);

    // max=0 up: one lap per cycle.
    write_seg(0, 8'd0, 1'b1, 4'd3, 4'd0);
    start_prog(1'b0, 8'd0, 1'b0, 4'd0, 4'd0);
    check_trace("max_zero", -1, -1, -1);

    // Every segment valid: program ends on the last index.
    write_seg(0, 8'd3, 1'b1, 4'd1, 4'd1);
    write_seg(1, 8'd2, 1'b0, 4'd2, 4'd0);
    write_seg(2, 8'd1, 1'b1, 4'd1, 4'd2);
    write_seg(3, 8'd4, 1'b0, 4'd1, 4'd0);
    start_prog(1'b0, 8'd0, 1'b0, 4'd0, 4'd0);
    check_trace("all_segments", -1, -1, -1);

    // Random programs.
    for (int it = 0; it < 8; it++) begin
      int nvalid;
      nvalid = int'($urandom_range(1, NSEG));
      for (int s = 0; s < NSEG; s++) begin
        write_seg(s, 8'($urandom_range(0, 24)), 1'($urandom_range(0, 1)),
                  (s < nvalid) ? 4'($urandom_range(1, 3)) : 4'd0,
                  4'($urandom_range(0, 3)));
      end
      start_prog(1'b0, 8'd0, 1'b0, 4'd0, 4'd0);
      check_trace("random", -1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
